// File: rtl/fsm_seq_pkg.sv
// -----------------------------------------------------------------------------
// fsm_seq_pkg
// Shared definitions for the go/jmp sequencer and anything that models it:
//   - S0..S9 : 4-bit state encodings of the 10-state sequencer
//   - seq_step_t : result of one model step (next state, expected Y, illegal flag)
//   - seq_next() : pure single-cycle step function of the sequencer
// -----------------------------------------------------------------------------
package fsm_seq_pkg;

  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;
  localparam logic [3:0] S6 = 4'd6;
  localparam logic [3:0] S7 = 4'd7;
  localparam logic [3:0] S8 = 4'd8;
  localparam logic [3:0] S9 = 4'd9;

  typedef struct packed {
    logic [3:0] nxt;      // next state
    logic       y;        // expected sequencer output this cycle
    logic       illegal;  // current state is one of the unused encodings 10..15
  } seq_step_t;

  // One step of the sequencer, evaluated on the current cycle's go/jmp.
  // Any jmp taken from a state that honours it lands in S3 with Y=1.
  function automatic seq_step_t seq_next(input logic [3:0] cur,
                                         input logic       go,
                                         input logic       jmp);
    seq_step_t r;
    r.nxt     = S0;
    r.y       = 1'b0;
    r.illegal = 1'b0;
    case (cur)
      S0: begin
        if (go && jmp) begin
          r.nxt = S3;
          r.y   = 1'b1;
        end else if (go) begin
          r.nxt = S1;
        end else begin
          r.nxt = S0;
        end
      end
      S1: begin
        if (jmp) begin
          r.nxt = S3;
          r.y   = 1'b1;
        end else begin
          r.nxt = S2;
        end
      end
      // S2 waits for jmp only; go has no effect here.
      S2: begin
        if (jmp) begin
          r.nxt = S3;
          r.y   = 1'b1;
        end else begin
          r.nxt = S2;
        end
      end
      S3, S4, S5, S6, S7: begin
        if (jmp) begin
          r.nxt = S3;
          r.y   = 1'b1;
        end else begin
          r.nxt = cur + 4'd1;
        end
      end
      // S8 is the only state whose fall-through transition drives Y high.
      S8: begin
        r.y = 1'b1;
        if (jmp) begin
          r.nxt = S3;
        end else begin
          r.nxt = S9;
        end
      end
      S9: begin
        if (jmp) begin
          r.nxt = S3;
          r.y   = 1'b1;
        end else begin
          r.nxt = S0;
        end
      end
      default: begin
        r.nxt     = S0;
        r.y       = 1'b0;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fsm_seq_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;

  // Count register: clear on reset, otherwise increment until all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fsm_seq_monitor.sv
// -----------------------------------------------------------------------------
// fsm_seq_monitor
// Passive checker for the go/jmp sequencer. Runs a shadow copy of the
// sequencer on the same go/jmp and compares the observed Y with the shadow's
// expected Y each enabled cycle. Also counts jmp transitions and completed
// S8->S9 sequences.
// Ports:
//   clk, rst    : shared clock, synchronous active-high reset
//   en          : checking enable (low while the sequencer is in reset)
//   go, jmp, y  : observed sequencer inputs and output
//   exp_y       : expected Y, combinational from shadow state and go/jmp
//   state       : shadow state (0..9)
//   err         : one-cycle registered mismatch pulse
//   err_sticky  : set on first mismatch, cleared only by rst
//   err_cnt     : saturating mismatch count
//   jmp_cnt     : saturating count of jmp->S3 transitions
//   seq_cnt     : saturating count of completed S8->S9 sequences
// -----------------------------------------------------------------------------
module fsm_seq_monitor
  import fsm_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             go,
  input  logic             jmp,
  input  logic             y,
  output logic             exp_y,
  output logic [3:0]       state,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] jmp_cnt,
  output logic [CNT_W-1:0] seq_cnt
);

  logic [3:0] state_r;
  logic [3:0] state_next_s;
  seq_step_t  step_s;
  logic       exp_y_s;
  logic       mismatch_s;
  logic       jmp_ev_s;
  logic       seq_ev_s;
  logic       err_r;
  logic       err_sticky_r;

  assign step_s = seq_next(state_r, go, jmp);

  // Shadow state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next shadow state; disabled monitor parks in S0 so checking restarts there.
  always_comb begin
    state_next_s = S0;
    if (en) begin
      state_next_s = step_s.nxt;
    end else begin
      state_next_s = S0;
    end
  end

  // Expected Y and per-cycle events; only enabled cycles produce events.
  // Every transition into S3 is a jmp transition, including the S3 self-loop.
  always_comb begin
    exp_y_s    = step_s.y;
    mismatch_s = en & (step_s.illegal | (y != step_s.y));
    jmp_ev_s   = en & ~step_s.illegal & (step_s.nxt == S3);
    seq_ev_s   = en & (state_r == S8) & ~jmp;
  end

  // Error pulse and sticky flag, one cycle behind the checked sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      err_r        <= mismatch_s;
      err_sticky_r <= err_sticky_r | mismatch_s;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch_s),
    .count (err_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_jmp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (jmp_ev_s),
    .count (jmp_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_seq_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (seq_ev_s),
    .count (seq_cnt)
  );

  assign exp_y      = exp_y_s;
  assign state      = state_r;
  assign err        = err_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: doc/fsm_seq_monitor.md
# fsm_seq_monitor

Passive checker on the `fsmg4` sequence interface (`go`, `jmp` in, `Y` out). It runs its own cycle-accurate model of the 10-state go/jmp sequencer and samples the same `go`/`jmp` the sequencer sees. Each cycle it compares the sequencer's `Y` against the expected value and flags mismatches. It also keeps event statistics, and sits beside the sequencer in benches and on-chip debug.

## Interface
Parameters:
- `CNT_W`, default 8: width of every statistics counter.

Ports:
- `clk`, in, 1: single clock. It is the same clock as the monitored sequencer.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: enables checking.
  - Drive low while the monitored sequencer is held in reset.
- `go`, in, 1: observed `go`.
- `jmp`, in, 1: observed `jmp`.
- `y`, in, 1: observed sequencer output `Y`.
- `exp_y`, out, 1: expected `Y`, combinational from shadow state, `go` and `jmp`.
- `state`, out, 4: shadow state, encoded 0–9.
- `err`, out, 1: registered one-cycle mismatch pulse.
- `err_sticky`, out, 1: set on first mismatch; cleared only by `rst`.
- `err_cnt`, out, `CNT_W`: mismatch count, saturating.
- `jmp_cnt`, out, `CNT_W`: count of cycles taking a `jmp` transition to S3, saturating.
- `seq_cnt`, out, `CNT_W`: count of completed S8→S9 sequences, saturating.

## Operation
- Shadow-model transitions and `exp_y`. All are evaluated on the current cycle's `go`/`jmp`.
  - S0:
    - `go & !jmp` → S1, `exp_y` 0.
    - `go & jmp` → S3, 1.
    - `!go` → S0, 0.
  - S1: `!jmp` → S2, 0; `jmp` → S3, 1.
  - S2: `jmp` → S3, 1; otherwise stays in S2, 0. `go` is ignored in S2.
  - S3–S7: `!jmp` → next state (S3→S4 … S7→S8), 0; `jmp` → S3, 1.
  - S8: `!jmp` → S9, 1; `jmp` → S3, 1.
  - S9: `!jmp` → S0, 0; `jmp` → S3, 1.
  - Encodings 10–15 are unreachable. If one is ever reached: next state S0, `exp_y` 0, and the cycle counts as a mismatch.
- Checking happens only when `en`=1.
  - A mismatch is `y != exp_y`.
  - A mismatch registers `err`=1 for one cycle, sets `err_sticky`, and increments `err_cnt`.
- No resynchronisation. After a mismatch the shadow keeps following its own model and never copies the DUT.
- `jmp_cnt` increments on every enabled cycle where `jmp`=1, except S0 with `go`=0 and S2… correction: it increments on every enabled cycle whose transition is the `jmp` → S3 transition. This includes the S3 self-loop.
- `seq_cnt` increments on an enabled S8 cycle with `jmp`=0.
- `en`=0:
  - Shadow is forced to S0 on the next edge.
  - No counter or error updates.
  - `exp_y` is still driven.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset: `rst`=1 at an edge gives `state`=S0 and clears `err`, `err_sticky` and all counters. `exp_y` then follows S0 combinationally.
- `rst` has priority over `en` and over any event in the same cycle.
- Reset mid-sequence drops the partial sequence without counting it.
- `state` updates one edge after the sampled `go`/`jmp`.
- `err` and all counters reflect the sample from the previous edge (latency 1).
- A mismatch and a `jmp`/`seq` event in the same cycle update all affected counters together.
- A counter already at its maximum, with a new event, stays at its maximum. `err` still pulses.
- `en` rising: the first checked cycle uses shadow S0.

## Structure
- Shared package `fsm_seq_pkg` holds:
  - state constants S0–S9 (4-bit);
  - a pure function `seq_next(state, go, jmp)` that returns next state and expected Y.
  - A future golden-model block will reuse the same package.
- One sub-module, `sat_counter` (parameter width; inputs `clk`, `rst`, `inc`; output count). It is instantiated three times.

## Test plan
- Reset with `rst`=1 for 2 cycles, then `en`=1:
  - `state`=0, `err_sticky`=0, all counters 0.
  - With `go`=0 the state stays S0 and `exp_y`=0.
- `go`=1, `jmp`=0 for 3 cycles from S0:
  - states S1, S2, S2;
  - `exp_y` 0 throughout;
  - with `y` matching, `err_cnt`=0.
- From S3 with `jmp`=0 for 7 cycles:
  - states S4…S9 then S0;
  - `exp_y`=1 only on the S8 cycle;
  - `seq_cnt`=1.
- Hold `jmp`=1 for 4 cycles from S5:
  - state goes S3 and stays there;
  - `exp_y`=1 every cycle;
  - `jmp_cnt`=4.
- Force `y`=1 while in S4 with `jmp`=0:
  - `err`=1 exactly one cycle later;
  - `err_cnt`=1 and `err_sticky`=1;
  - shadow still advances to S5.
- Saturation and priority, with `CNT_W`=2:
  - 5 mismatches leave `err_cnt`=3, with `err` pulsing 5 times.
  - Asserting `rst` together with a mismatch clears everything and produces no `err` pulse.
